// File: rtl/tile_draw_datapath.sv
// Tile draw datapath: LFSR tile picker, tile register and pixel sweeper feeding the VGA adapter.
// Define TILE_OUTLINE_EN to draw each tile's border pixels in white.
module tile_draw_datapath #(
  parameter int         TILE_SIZE = 32,
  parameter int         GAP       = 8,
  parameter int         X0        = 40,
  parameter int         Y0        = 20,
  parameter logic [2:0] FLASH_COL = 3'b111
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       randomEnable,
  input  logic       ld_tile,
  input  logic       ld_flash,
  input  logic       ld_previous,
  output logic [1:0] rand_tile,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       drw
);

  localparam int            CW     = $clog2(TILE_SIZE);
  localparam logic [CW-1:0] C_MAX  = CW'(TILE_SIZE - 1);
  localparam logic [7:0]    X_BASE = 8'(X0);
  localparam logic [7:0]    X_STEP = 8'(TILE_SIZE + GAP);
  localparam logic [6:0]    Y_BASE = 7'(Y0);
  localparam logic [6:0]    Y_STEP = 7'(TILE_SIZE + GAP);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [1:0]    tile_reg_q, tile_reg_d;
  logic [1:0]    draw_tile_q, draw_tile_d;
  logic [2:0]    draw_col_q, draw_col_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          drw_q, drw_d;

  logic start;
  logic last_px;
  logic advance;
  logic emit;

  function automatic logic [2:0] base_colour(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  assign start   = ld_flash | ld_previous;
  assign last_px = (cx_q == C_MAX) && (cy_q == C_MAX);
  assign advance = (state_q == S_SWEEP) && !last_px;
  // The output registers are loaded with the pixel the counters move to, so
  // a strobe at edge t already shows pixel (0,0) during cycle t+1.
  assign emit    = start | advance;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    if (start) begin
      state_d = S_SWEEP;
    end else begin
      case (state_q)
        S_SWEEP: if (last_px) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    lfsr_d      = randomEnable ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                               : lfsr_q;
    tile_reg_d  = ld_tile ? lfsr_q[1:0] : tile_reg_q;
    draw_tile_d = draw_tile_q;
    draw_col_d  = draw_col_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = emit;
    drw_d       = !start && (state_q == S_SWEEP) && last_px;

    if (start) begin
      draw_tile_d = tile_reg_q;
      draw_col_d  = ld_flash ? FLASH_COL : base_colour(tile_reg_q);
      cx_d        = '0;
      cy_d        = '0;
    end else if (advance) begin
      cx_d = cx_q + CW'(1);
      if (cx_q == C_MAX) cy_d = cy_q + CW'(1);
    end

    if (emit) begin
      x_d = X_BASE + (draw_tile_d[0] ? X_STEP : 8'd0) + 8'(cx_d);
      y_d = Y_BASE + (draw_tile_d[1] ? Y_STEP : 7'd0) + 7'(cy_d);
`ifdef TILE_OUTLINE_EN
      if (cx_d == '0 || cx_d == C_MAX || cy_d == '0 || cy_d == C_MAX) colour_d = 3'b111;
      else                                                            colour_d = draw_col_d;
`else
      colour_d = draw_col_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lfsr_q      <= 8'h01;
      tile_reg_q  <= '0;
      draw_tile_q <= '0;
      draw_col_q  <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      drw_q       <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      tile_reg_q  <= tile_reg_d;
      draw_tile_q <= draw_tile_d;
      draw_col_q  <= draw_col_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      drw_q       <= drw_d;
    end
  end

  assign rand_tile = lfsr_q[1:0];
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign drw       = drw_q;

endmodule

// File: tb/tb_tile_draw_datapath.sv
// Self-checking bench for tile_draw_datapath: pixel-index reference model plus directed literal checks.
module tb_tile_draw_datapath;

  localparam int TS   = 32;
  localparam int GAP  = 8;
  localparam int X0   = 40;
  localparam int Y0   = 20;
  localparam int N    = TS * TS;
  localparam int STEP = TS + GAP;
`ifdef TILE_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn, randomEnable, ld_tile, ld_flash, ld_previous;
  logic [1:0] rand_tile;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, drw;

  int n_tests = 0;
  int n_fail  = 0;

  tile_draw_datapath #(.TILE_SIZE(TS), .GAP(GAP), .X0(X0), .Y0(Y0), .FLASH_COL(3'b111)) dut (
    .clock(clock), .resetn(resetn), .randomEnable(randomEnable), .ld_tile(ld_tile),
    .ld_flash(ld_flash), .ld_previous(ld_previous), .rand_tile(rand_tile),
    .x(x), .y(y), .colour(colour), .plot(plot), .drw(drw)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (pixel-index view of a sweep) ----------------
  logic [7:0] m_lfsr;
  logic [1:0] m_tile_reg, m_draw;
  logic [2:0] m_col;
  bit         m_active, m_drw, model_valid = 1'b0;
  int         m_k;

  function automatic int pal(input int t);
    case (t)
      0: return 4;
      1: return 2;
      2: return 1;
      default: return 6;
    endcase
  endfunction

  always @(posedge clock) begin
    logic [7:0] old_lfsr;
    if (!resetn) begin
      m_lfsr = 8'h01; m_tile_reg = 0; m_draw = 0; m_col = 0;
      m_active = 0; m_drw = 0; m_k = 0; model_valid = 1'b1;
    end else begin
      old_lfsr = m_lfsr;
      if (ld_flash || ld_previous) begin
        m_draw = m_tile_reg;
        m_col  = ld_flash ? 3'd7 : 3'(pal(m_tile_reg));
        m_k = 0; m_active = 1; m_drw = 0;
      end else if (m_active) begin
        m_k++;
        if (m_k == N) begin m_active = 0; m_drw = 1; end
      end else begin
        m_drw = 0;
      end
      if (ld_tile)      m_tile_reg = old_lfsr[1:0];
      if (randomEnable) m_lfsr = {old_lfsr[6:0], ^(old_lfsr & 8'hB8)};
    end
  end

  always @(negedge clock) begin
    int cx, cy, ec;
    if (model_valid) begin
      check("plot", plot, m_active);
      check("drw", drw, m_drw);
      check("rand_tile", rand_tile, m_lfsr[1:0]);
      if (m_active) begin
        cx = m_k % TS;
        cy = m_k / TS;
        ec = (OUTLINE && (cx == 0 || cy == 0 || cx == TS - 1 || cy == TS - 1)) ? 7 : m_col;
        check("x", x, X0 + (m_draw % 2) * STEP + cx);
        check("y", y, Y0 + (m_draw / 2) * STEP + cy);
        check("colour", colour, ec);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input bit f, input bit p);
    ld_flash = f; ld_previous = p;
    tick();
    ld_flash = 0; ld_previous = 0;
  endtask

  task automatic load_tile(input int t);
    for (int i = 0; i < 300 && rand_tile != 2'(t); i++) begin
      randomEnable = 1; tick(); randomEnable = 0;
    end
    check("lfsr_search", rand_tile, t);
    ld_tile = 1; tick(); ld_tile = 0;
  endtask

  initial begin
    int cnt, drws, r;
    resetn = 0; randomEnable = 0; ld_tile = 0; ld_flash = 0; ld_previous = 0;
    tick(); tick();
    check("rst_plot", plot, 0);
    check("rst_drw", drw, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_rand_tile", rand_tile, 1);
    resetn = 1;

    randomEnable = 1; tick(); randomEnable = 0;
    check("lfsr_first_step", rand_tile, 2);
    ld_tile = 1; tick(); ld_tile = 0;

    // flash sweep of tile 2
    strobe(1, 0);
    check("flash_first_x", x, 40);
    check("flash_first_y", y, 60);
    check("flash_colour", colour, 7);
    cnt = plot;
    repeat (N - 1) begin tick(); cnt += plot; end
    check("flash_last_x", x, 71);
    check("flash_last_y", y, 91);
    tick();
    check("flash_plot_count", cnt, 1024);
    check("flash_drw_high", drw, 1);
    check("flash_plot_low", plot, 0);
    tick();
    check("flash_drw_one_cycle", drw, 0);

    // restore sweeps
    strobe(0, 1);
    check("restore2_colour", colour, 1);
    check("restore2_x", x, 40);
    repeat (N + 1) tick();
    load_tile(3);
    strobe(0, 1);
    check("restore3_x", x, 80);
    check("restore3_y", y, 60);
    check("restore3_colour", colour, 6);
    repeat (N + 1) tick();

    // abort a flash sweep at pixel 100
    strobe(1, 0);
    repeat (100) tick();
    check("abort_px100_x", x, 84);
    check("abort_px100_y", y, 63);
    strobe(0, 1);
    check("abort_restart_x", x, 80);
    check("abort_restart_y", y, 60);
    check("abort_restart_colour", colour, 6);
    cnt = plot; drws = 0;
    repeat (N + 6) begin tick(); cnt += plot; drws += drw; end
    check("abort_plot_count", cnt, 1024);
    check("abort_drw_count", drws, 1);

    // simultaneous strobes
    strobe(1, 1);
    check("priority_colour", colour, 7);
    repeat (N + 1) tick();

    // outline / interior of tile 0
    load_tile(0);
    strobe(0, 1);
    check("t0_corner_x", x, 40);
    check("t0_corner_y", y, 20);
    check("t0_corner_colour", colour, OUTLINE ? 7 : 4);
    repeat (TS + 1) tick();
    check("t0_inner_x", x, 41);
    check("t0_inner_y", y, 21);
    check("t0_inner_colour", colour, 4);
    repeat (N - TS - 2) tick();
    check("t0_last_x", x, 71);
    check("t0_last_y", y, 51);
    check("t0_last_colour", colour, OUTLINE ? 7 : 4);
    repeat (2) tick();

    // reset mid-sweep
    strobe(1, 0);
    repeat (5) tick();
    resetn = 0; tick();
    check("midrst_plot", plot, 0);
    check("midrst_rand_tile", rand_tile, 1);
    resetn = 1;

    // randomized traffic against the model
    repeat (3000) begin
      randomEnable = 1'($urandom % 2);
      ld_tile      = ($urandom % 8) == 0;
      r            = int'($urandom % 200);
      ld_flash     = r < 3;
      ld_previous  = r >= 2 && r < 5;
      resetn       = ($urandom % 1000) != 0;
      tick();
    end
    randomEnable = 0; ld_tile = 0; ld_flash = 0; ld_previous = 0; resetn = 1;
    repeat (N + 4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_draw_datapath.md
# tile_draw_datapath

Datapath stage directly downstream of the graphics control FSM in the tile-memory game. It consumes the FSM's `ld_tile`, `ld_flash`, `ld_previous` and `randomEnable` strobes. It holds the random tile generator and the selected tile. It sweeps the selected tile's pixels into the 160x120 VGA adapter as `x`/`y`/`colour`/`plot`, and returns a one-cycle `drw` pulse when a sweep completes.

## Interface
Parameters:
- `TILE_SIZE`, 32: tile side in pixels; must be a power of two, ≤ 32.
- `GAP`, 8: pixel gap between adjacent tiles.
- `X0`, 40: x origin of tile 0.
- `Y0`, 20: y origin of tile 0.
- `FLASH_COL`, 3'b111: colour used for flashing.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `randomEnable`  in  1  advance the LFSR this cycle.
- `ld_tile`  in  1  capture `rand_tile` into the tile register.
- `ld_flash`  in  1  start a sweep of the current tile in `FLASH_COL`.
- `ld_previous`  in  1  start a sweep of the current tile in its base colour.
- `rand_tile`  out  2  LFSR bits [1:0].
- `x`  out  8  pixel x.
- `y`  out  7  pixel y.
- `colour`  out  3  pixel colour.
- `plot`  out  1  write strobe to the VGA adapter.
- `drw`  out  1  one-cycle sweep-complete pulse.

## Operation
- **LFSR.** 8-bit register, reset value 8'h01. On `randomEnable`: shift left, new bit[0] = b7^b5^b4^b3. The LFSR never reaches zero.
- **Tile register.** `tile_reg` resets to 0. On `ld_tile`: `tile_reg` <= `rand_tile`.
- **Base palette.** Tile 0 = 3'b100, tile 1 = 3'b010, tile 2 = 3'b001, tile 3 = 3'b110.
- **Tile origins.** Tile column = `tile[0]`, tile row = `tile[1]`.
  - ox = X0 + col·(TILE_SIZE+GAP)
  - oy = Y0 + row·(TILE_SIZE+GAP)
- **Sweep start.** On `ld_flash` or `ld_previous`, the block latches `draw_tile` <= `tile_reg` and the draw colour. It clears counters `cx` and `cy`, sets `busy`, and clears `drw`.
- **Sweep progression.** Each busy cycle emits one pixel:
  - `x` = ox+cx, `y` = oy+cy, `plot` = 1.
  - Scan order: `cx` fastest, then `cy`.
  - After pixel (TILE_SIZE-1, TILE_SIZE-1), `busy` clears.
- **FSM states.** IDLE → (ld_flash|ld_previous) → SWEEP → (last pixel) → DONE (`drw`=1, one cycle) → IDLE.
- **Simultaneous strobes.** `ld_flash` and `ld_previous` in the same cycle: `ld_flash` wins.
- **`ld_*` during SWEEP.** Aborts the current sweep and restarts from (0,0) with the new colour and tile. No `drw` is generated for the aborted sweep.
- **`ld_tile` during SWEEP.** Updates `tile_reg` only; the in-flight sweep continues with the latched `draw_tile`.
- **`randomEnable`.** Independent of the sweep; it may coincide with any state.
- **Width rules.** `cx`/`cy` are log2(TILE_SIZE) bits. The x/y adds are computed at 8/7 bits. Parameters must keep all pixels within 160x120; no clipping is performed.

## Timing
- **Reset values.** `x`=0, `y`=0, `colour`=0, `plot`=0, `drw`=0, `busy`=0, `rand_tile`=2'b01. Reset mid-sweep stops the sweep immediately: `plot` is 0 in the next cycle.
- **Registered outputs.** All outputs are registered.
  - Strobe sampled at edge t → first pixel valid in cycle t+1.
  - Pixel k valid in cycle t+1+k.
  - Last pixel in cycle t+N, where N = TILE_SIZE².
  - `drw` high in cycle t+N+1 only.
- **`plot` contiguity.** `plot` is high for exactly N contiguous cycles per uninterrupted sweep.
- **LFSR timing.** `rand_tile` reflects the LFSR value one edge after `randomEnable` is sampled.

## Configuration
- **`TILE_OUTLINE_EN` defined:** pixels with `cx` or `cy` equal to 0 or TILE_SIZE-1 are emitted in 3'b111. Interior pixels use the draw colour.
- **`TILE_OUTLINE_EN` undefined:** every pixel uses the draw colour. Timing is identical in both builds.

## Test plan
- **Reset.** Hold `resetn`=0 for 2 cycles → `plot`=0, `drw`=0, `x`=0, `y`=0, `colour`=0, `rand_tile`=2'b01.
- **LFSR and tile load.** One `randomEnable` cycle from reset → LFSR 8'h02, `rand_tile`=2'b10. Then `ld_tile` → `tile_reg`=2.
- **Flash sweep.** `ld_flash` with tile 2 → 1024 `plot` cycles, first (40,60), last (71,91), `colour` 3'b111; `drw` high exactly one cycle after the last pixel.
- **Restore sweep.** `ld_previous` with tile 2 → 1024 pixels in 3'b001; with tile 3 → origin (80,60), colour 3'b110.
- **Abort and strobe priority.**
  - `ld_previous` at pixel 100 of a flash sweep → next pixel is (ox,oy) in base colour, 1024 further plots, a single `drw`.
  - `ld_flash` and `ld_previous` in the same cycle → flash colour.
- **Outline.** With `TILE_OUTLINE_EN`, restore of tile 0 → pixel (40,20) = 3'b111, pixel (41,21) = 3'b100, pixel (71,51) = 3'b111.
